// File: rtl/seg_pkg.sv
// Shared types and active-low hex glyph constants for the seg_mux_n display driver.
// Segment order everywhere is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF_AL = 7'b1111111;

  localparam seg7_t GLYPH_0 = 7'b1000000;
  localparam seg7_t GLYPH_1 = 7'b1111001;
  localparam seg7_t GLYPH_2 = 7'b0100100;
  localparam seg7_t GLYPH_3 = 7'b0110000;
  localparam seg7_t GLYPH_4 = 7'b0011001;
  localparam seg7_t GLYPH_5 = 7'b0010010;
  localparam seg7_t GLYPH_6 = 7'b0000010;
  localparam seg7_t GLYPH_7 = 7'b1111000;
  localparam seg7_t GLYPH_8 = 7'b0000000;
  localparam seg7_t GLYPH_9 = 7'b0010000;
  localparam seg7_t GLYPH_A = 7'b0001000;
  localparam seg7_t GLYPH_B = 7'b0000011;  // lowercase b
  localparam seg7_t GLYPH_C = 7'b1000110;
  localparam seg7_t GLYPH_D = 7'b0100001;  // lowercase d
  localparam seg7_t GLYPH_E = 7'b0000110;
  localparam seg7_t GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  always_comb begin
    seg_o = SEG_OFF_AL;
    case (nibble_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = SEG_OFF_AL;
    endcase
  end

endmodule

// File: rtl/seg_mux_n.sv
// Time-multiplexed N-digit hex display driver with frame-synchronous double buffering,
// per-slot guard time and frame-done strobe. Optional dimming via `define SEG_DIM_EN.
module seg_mux_n
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 48000,
  parameter int GUARD_CYCLES   = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
`ifdef SEG_DIM_EN
  input  logic [2:0]              brightness,
`endif
  output seg7_t                   seg,
  output logic [NUM_DIGITS-1:0]   select,
  output logic                    frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] PRE_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] PRE_GUARD = CW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
  localparam seg7_t SEG_OFF = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_AL : ~SEG_OFF_AL;

  logic [CW-1:0]           pre_cnt_q, pre_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
  seg7_t                   seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    frame_done_q;

  logic                    slot_end, frame_end, lit;
  logic [3:0]              cur_nibble;
  logic [4*NUM_DIGITS-1:0] dig_shift;
  logic [NUM_DIGITS-1:0]   blank_shift;
  seg7_t                   dec_al;

  assign slot_end  = (pre_cnt_q == PRE_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  assign dig_shift   = act_dig_q >> {idx_q, 2'b00};
  assign blank_shift = act_blank_q >> idx_q;
  assign cur_nibble  = dig_shift[3:0];

  seg_hex_decoder u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (dec_al)
  );

`ifdef SEG_DIM_EN
  logic [2:0]    bright_q, bright_eff;
  logic [CW+3:0] lit_limit;

  // Brightness is taken live on pre_cnt == 0 so a zero guard still sees this slot's value.
  assign bright_eff = (pre_cnt_q == '0) ? brightness : bright_q;
  assign lit_limit  = (CW+4)'({1'b0, bright_eff} + 4'd1) * (CW+4)'(REFRESH_DIV / 8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bright_q <= 3'd7;
    else       bright_q <= bright_eff;
  end

  assign lit = (pre_cnt_q >= PRE_GUARD) && !blank_shift[0] &&
               ({4'b0000, pre_cnt_q} < lit_limit);
`else
  assign lit = (pre_cnt_q >= PRE_GUARD) && !blank_shift[0];
`endif

  always_comb begin
    pre_cnt_d = slot_end ? '0 : pre_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // A load on the frame-end cycle goes straight through pending into active.
    pend_dig_d   = load ? digits : pend_dig_q;
    pend_blank_d = load ? blank  : pend_blank_q;
    act_dig_d    = frame_end ? pend_dig_d   : act_dig_q;
    act_blank_d  = frame_end ? pend_blank_d : act_blank_q;

    sel_d = lit ? (SEL_ONE << idx_q) : '0;
    seg_d = SEG_OFF;
    if (lit) seg_d = (SEG_ACTIVE_LOW != 0) ? dec_al : ~dec_al;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt_q    <= '0;
      idx_q        <= '0;
      act_dig_q    <= '0;
      pend_dig_q   <= '0;
      act_blank_q  <= '1;
      pend_blank_q <= '1;
      seg_q        <= SEG_OFF;
      sel_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pre_cnt_q    <= pre_cnt_d;
      idx_q        <= idx_d;
      act_dig_q    <= act_dig_d;
      pend_dig_q   <= pend_dig_d;
      act_blank_q  <= act_blank_d;
      pend_blank_q <= pend_blank_d;
      seg_q        <= seg_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_end;
    end
  end

  assign seg        = seg_q;
  assign select     = sel_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_mux_n.sv
// Directed-plus-random bench for seg_mux_n with a slot-time reference model of the display.
module tb_seg_mux_n;

  localparam int N = 2;
  localparam int R = 8;
  localparam int G = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   digits = 8'h00;
  logic [1:0]   blank = 2'b11;
  logic         load = 1'b0;
`ifdef SEG_DIM_EN
  logic [2:0]   brightness = 3'd7;
  int           bright_m;
`endif
  logic [6:0]   seg;
  logic [1:0]   select;
  logic         frame_done;

  int errors = 0;
  int checks = 0;

  int         t;
  logic [7:0] act_d, pend_d;
  logic [1:0] act_b, pend_b;

  always #5 clk = ~clk;

  seg_mux_n #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (R),
    .GUARD_CYCLES   (G),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digits     (digits),
    .blank      (blank),
    .load       (load),
`ifdef SEG_DIM_EN
    .brightness (brightness),
`endif
    .seg        (seg),
    .select     (select),
    .frame_done (frame_done)
  );

  // Glyphs described by which segments are lit, then converted to active-low bits.
  function automatic logic [6:0] glyph_al(input logic [3:0] n);
    string s;
    logic [6:0] g;
    case (n)
      4'h0: s = "abcdef";  4'h1: s = "bc";     4'h2: s = "abdeg";  4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";  4'h6: s = "acdefg"; 4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg"; 4'hA: s = "abcefg"; 4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";  4'hE: s = "adefg";  default: s = "aefg";
    endcase
    g = 7'h7F;
    for (int i = 0; i < s.len(); i++) g[int'(s[i]) - 97] = 1'b0;
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0;
    act_d = 8'h00; pend_d = 8'h00;
    act_b = 2'b11; pend_b = 2'b11;
`ifdef SEG_DIM_EN
    bright_m = 7;
`endif
  endtask

  // One clock: predict outputs from slot position and active buffer, advance the model, compare.
  task automatic tick();
    int pre, idx;
    logic lit, fend;
    logic [6:0] e_seg;
    logic [1:0] e_sel;
    pre  = t % R;
    idx  = (t / R) % N;
    lit  = (pre >= G) && !act_b[idx];
`ifdef SEG_DIM_EN
    if (pre == 0) bright_m = int'(brightness);
    lit = lit && (pre < (bright_m + 1) * R / 8);
`endif
    e_seg = lit ? glyph_al(act_d[idx*4 +: 4]) : 7'h7F;
    e_sel = lit ? 2'(1 << idx) : 2'b00;
    fend  = (pre == R - 1) && (idx == N - 1);
    if (load) begin pend_d = digits; pend_b = blank; end
    if (fend) begin act_d = pend_d; act_b = pend_b; end
    t++;
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("select", 32'(select), 32'(e_sel));
    check("frame_done", 32'(frame_done), 32'(fend));
  endtask

  task automatic do_load(input logic [7:0] d, input logic [1:0] b);
    digits = d; blank = b; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int first_fd;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_select", 32'(select), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    reset = 1'b0;

    // First frame dark; A5 shown from the second frame; first strobe after 16 cycles.
    tick();
    first_fd = -1;
    digits = 8'hA5; blank = 2'b00; load = 1'b1;
    tick();
    load = 1'b0;
    for (int k = 3; k <= 3 * N * R; k++) begin
      tick();
      if (frame_done && first_fd < 0) first_fd = k;
    end
    check("first_frame_done_cycle", 32'(first_fd), 32'd16);

    // Mid-frame load must not tear the frame in progress.
    repeat (5) tick();
    do_load(8'h1F, 2'b00);
    repeat (2 * N * R) tick();

    // Load landing exactly on the frame-end cycle.
    while (!((t % R == R - 1) && ((t / R) % N == N - 1))) tick();
    do_load(8'h80, 2'b00);
    repeat (2 * N * R) tick();

    // Digit 1 blanked.
    do_load(8'h3C, 2'b10);
    repeat (2 * N * R) tick();

    // Random loads, digits, blanks and (when present) brightness.
    for (int k = 0; k < 400; k++) begin
      load = ($urandom_range(0, 5) == 0);
      digits = 8'($urandom);
      blank = 2'($urandom_range(0, 3));
`ifdef SEG_DIM_EN
      brightness = 3'($urandom_range(0, 7));
`endif
      tick();
    end
    load = 1'b0;
`ifdef SEG_DIM_EN
    brightness = 3'd3;
    repeat (2 * N * R) tick();
    brightness = 3'd0;
    repeat (2 * N * R) tick();
    brightness = 3'd7;
`endif

    // Make sure something is lit, then reset mid-slot: dark immediately and stays dark.
    do_load(8'h77, 2'b00);
    while (select == 2'b00) tick();
    #2;
    reset = 1'b1;
    #1;
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_select", 32'(select), 32'h0);
    check("midrst_frame_done", 32'(frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_hold_seg", 32'(seg), 32'h7F);
    reset = 1'b0;
    model_reset();
    repeat (N * R) tick();
    do_load(8'h4E, 2'b01);
    repeat (2 * N * R) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
